// File: rtl/alu_cmp_pkg.sv
// alu_cmp_pkg: state and result encodings shared by the serial and parallel comparators
package alu_cmp_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [2:0] CMP_LS = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_GT = 3'b001;
  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN = ST_RUN,
    S_DONE = ST_DONE
  } cmp_state_t;
endpackage

// File: rtl/serial_comparator_if.sv
// serial_comparator_if: start/operand request and ready/busy/done/result response bundle
interface serial_comparator_if #(parameter int WIDTH = 16);
  logic start, sgn, ready, busy, done, ls, eq, gt;
  logic [WIDTH-1:0] a, b;
  modport master(output start, a, b, sgn, input ready, busy, done, ls, eq, gt);
  modport slave(input start, a, b, sgn, output ready, busy, done, ls, eq, gt);
endinterface

// File: rtl/bit_cmp_step.sv
// bit_cmp_step: 1-bit magnitude compare; invert swaps lt/gt for a two's-complement sign bit
module bit_cmp_step (
  input  logic a_bit,
  input  logic b_bit,
  input  logic invert,
  output logic lt,
  output logic gt,
  output logic neq
);
  assign neq = a_bit ^ b_bit;
  assign lt = invert ? (a_bit & ~b_bit) : (~a_bit & b_bit);
  assign gt = invert ? (~a_bit & b_bit) : (a_bit & ~b_bit);
endmodule

// File: rtl/serial_comparator.sv
// serial_comparator: MSB-first bit-serial magnitude compare with early exit and done pulse.
// Define SIGNED_CMP_EN to honour sgn (two's-complement compare); otherwise sgn is ignored.
module serial_comparator
  import alu_cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input logic clk,
  input logic rst_n,
  serial_comparator_if.slave cmp
);
`ifdef SIGNED_CMP_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);
  cmp_state_t state;
  logic [WIDTH-1:0] a_r, b_r;
  logic sgn_r;
  logic [IDX_W-1:0] idx;
  logic lt_bit, gt_bit, neq_bit, invert;
  // only the sign bit flips its ordering in a signed compare
  assign invert = SIGNED_EN && sgn_r && (idx == IDX_MSB);
  bit_cmp_step u_step (
    .a_bit(a_r[idx]),
    .b_bit(b_r[idx]),
    .invert(invert),
    .lt(lt_bit),
    .gt(gt_bit),
    .neq(neq_bit)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= S_IDLE;
      cmp.ready <= 1'b1;
      cmp.busy <= 1'b0;
      cmp.done <= 1'b0;
      {cmp.ls, cmp.eq, cmp.gt} <= CMP_EQ;
      idx <= '0;
      a_r <= '0;
      b_r <= '0;
      sgn_r <= 1'b0;
    end else begin
      cmp.done <= 1'b0;
      case (state)
        S_IDLE:
          if (cmp.start) begin
            a_r <= cmp.a;
            b_r <= cmp.b;
            sgn_r <= cmp.sgn;
            idx <= IDX_MSB;
            state <= S_RUN;
            cmp.ready <= 1'b0;
            cmp.busy <= 1'b1;
          end
        S_RUN:
          if (neq_bit || idx == '0) begin
            {cmp.ls, cmp.eq, cmp.gt} <= neq_bit ? {lt_bit, 1'b0, gt_bit} : CMP_EQ;
            state <= S_DONE;
            cmp.busy <= 1'b0;
            cmp.done <= 1'b1;
          end else
            idx <= idx - 1'b1;
        S_DONE: begin
          state <= S_IDLE;
          cmp.ready <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          cmp.ready <= 1'b1;
          cmp.busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_serial_comparator.sv
// tb_serial_comparator: directed checks of reset, latency, early exit, mid-run reset and back-to-back starts
module tb_serial_comparator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  serial_comparator_if #(.WIDTH(16)) bus ();
  serial_comparator #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .cmp(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run(input string tag, input logic [15:0] av, input logic [15:0] bv, input logic s,
                     input int exp_cyc, input logic [2:0] exp_f, input bit poke);
    int n, nb;
    @(negedge clk);
    bus.start = 1'b1; bus.a = av; bus.b = bv; bus.sgn = s;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    nb = 0;
    while (!bus.done && n <= 40) begin
      if (bus.busy) nb++;
      if (poke && n == 3) bus.a = 16'hFFFF;
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_cycle"}, n, exp_cyc);
    chk({tag, "_busy_cycles"}, nb, exp_cyc - 1);
    chk({tag, "_flags"}, {bus.ls, bus.eq, bus.gt}, exp_f);
    @(negedge clk);
    chk({tag, "_idle_ready"}, {bus.ready, bus.busy, bus.done}, 3'b100);
    chk({tag, "_flags_hold"}, {bus.ls, bus.eq, bus.gt}, exp_f);
  endtask
  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.sgn = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ready", bus.ready, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_ls", bus.ls, 1'b0);
    chk("rst_eq", bus.eq, 1'b1);
    chk("rst_gt", bus.gt, 1'b0);
    run("equal", 16'h0001, 16'h0001, 1'b0, 17, 3'b010, 1'b0);
    run("early_ls", 16'h0002, 16'h4000, 1'b0, 3, 3'b100, 1'b0);
    run("early_gt", 16'h4840, 16'h1CE0, 1'b0, 3, 3'b001, 1'b0);
    run("late_ls", 16'h0002, 16'h0003, 1'b0, 17, 3'b100, 1'b1);
    // reset at RUN cycle 5 of a compare that would otherwise end gt
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h0001; bus.b = 16'h0000; bus.sgn = 1'b0;
    @(negedge clk);
    repeat (4) @(negedge clk);
    chk("midrun_busy", bus.busy, 1'b1);
    chk("midrun_flags_stable", {bus.ls, bus.eq, bus.gt}, 3'b100);
    rst_n = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrun_rst_state", {bus.ready, bus.busy, bus.done}, 3'b100);
    chk("midrun_rst_flags", {bus.ls, bus.eq, bus.gt}, 3'b010);
    repeat (20) begin
      @(negedge clk);
      chk("midrun_no_done", bus.done, 1'b0);
    end
    // start held high: accepted again only once ready returns
    bus.start = 1'b1; bus.a = 16'h8000; bus.b = 16'h0000; bus.sgn = 1'b0;
    @(negedge clk);
    chk("b2b_c1_busy", bus.busy, 1'b1);
    @(negedge clk);
    chk("b2b_c2_done", {bus.ready, bus.busy, bus.done}, 3'b001);
    chk("b2b_c2_flags", {bus.ls, bus.eq, bus.gt}, 3'b001);
    @(negedge clk);
    chk("b2b_c3_idle", {bus.ready, bus.busy, bus.done}, 3'b100);
    bus.a = 16'h0000; bus.b = 16'h8000;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_c4_busy", {bus.ready, bus.busy, bus.done}, 3'b010);
    @(negedge clk);
    chk("b2b_c5_done", bus.done, 1'b1);
    chk("b2b_c5_flags", {bus.ls, bus.eq, bus.gt}, 3'b100);
`ifdef SIGNED_CMP_EN
    run("signed_neg", 16'h8000, 16'h0001, 1'b1, 2, 3'b100, 1'b0);
`else
    run("sgn_ignored", 16'h8000, 16'h0001, 1'b1, 2, 3'b001, 1'b0);
`endif
    run("unsigned_msb", 16'h8000, 16'h0001, 1'b0, 2, 3'b001, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_comparator.md
Name: serial_comparator

Overview:
- Sequential, bit-serial counterpart to the team's parallel tree magnitude comparator.
- Captures two WIDTH-bit operands on a start handshake and walks them MSB-first, one bit per clock.
- Terminates early on the first differing bit and reports ls/eq/gt, with a done pulse.
- Used in area-constrained ALU paths where a multi-cycle compare is acceptable.

Parameters:
- WIDTH, 16, operand width in bits (legal range 2..64).
- IDX_W, $clog2(WIDTH), width of the internal bit-index counter.

Ports:
- clk    input   1      single clock; all state updates on rising edge
- rst_n  input   1      synchronous, active-low reset
- start  input   1      request compare; accepted only when ready=1
- a      input   WIDTH  operand A; sampled on the accepting edge only
- b      input   WIDTH  operand B; sampled on the accepting edge only
- sgn    input   1      signed-compare request; sampled with a/b; ignored unless SIGNED_CMP_EN
- ready  output  1      1 in IDLE
- busy   output  1      1 in RUN
- done   output  1      one-cycle pulse; ls/eq/gt are final in this cycle
- ls     output  1      a < b
- eq     output  1      a == b
- gt     output  1      a > b

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous, active-low (rst_n).
- Reset (rst_n=0 at an edge): state=IDLE, ready=1, busy=0, done=0, ls=0, eq=1, gt=0, idx=0, operand registers=0.
- Reset mid-RUN or in DONE aborts the compare; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge captures a, b, sgn, sets idx=WIDTH-1, and moves to RUN.
  - start=0 holds state.
  - Result flags hold their last values.
- RUN: each edge examines bit idx of the captured operands.
  - Bits differ: set ls=~a[idx]&b[idx], gt=a[idx]&~b[idx], eq=0; go to DONE.
  - Bits equal and idx==0: set ls=0, eq=1, gt=0; go to DONE.
  - Otherwise: idx decrements by 1 and the state stays in RUN.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- start is ignored in RUN and DONE; no queuing.
- Latency: the start edge is E0. A first mismatch at bit i is resolved at edge E(WIDTH-i), and done is high in the following cycle. Equal operands resolve at E(WIDTH), so done is high in cycle WIDTH+1.
- Result flags change only on the resolving edge. They hold stable from the done cycle until the next compare resolves, and are never updated mid-run.
- Invariant: exactly one of ls/eq/gt is 1 at all times after reset.
- a/b changes after acceptance have no effect on the running compare.
- Back-to-back: start may be asserted in the DONE cycle, but it is only accepted on the edge after DONE, when ready=1.
- Minimum period between accepts: 3 cycles (accept edge, one RUN edge, the DONE-to-IDLE edge).

Optional Feature:
- Macro: SIGNED_CMP_EN.
- Defined:
  - When captured sgn=1, the MSB step (idx==WIDTH-1) inverts its ls/gt decision: a[MSB]=1 and b[MSB]=0 gives ls=1.
  - Operands are treated as two's complement.
  - Lower bits behave unchanged.
  - Latency is unchanged.
- Not defined: sgn is accepted but ignored; the compare is always unsigned. The port list is identical in both builds.

Decomposition:
- Shared package alu_cmp_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - result encoding constants CMP_LS, CMP_EQ, CMP_GT, shared with the parallel comparator's consumers.
- One natural sub-module: bit_cmp_step. It is a combinational 1-bit compare of a_bit, b_bit and invert → lt, gt, neq, instantiated once and driven by the idx mux.
- FSM and counter stay in the top module.

Test Plan:
- Reset: rst_n=0 for 2 cycles → ready=1, busy=0, done=0, ls=0, eq=1, gt=0.
- Equal operands: a=b=16'h0001, start for 1 cycle → busy for 16 cycles, done high in cycle 17, eq=1, ls=gt=0.
- Early exit at MSB: a=16'h0002, b=16'h4000 → mismatch at bit 14, done in cycle 3 after start, ls=1. Then a=16'h4840, b=16'h1CE0 → mismatch at bit 14, gt=1, done in cycle 3.
- Late exit: a=16'h0002, b=16'h0003 → mismatch at bit 0, done in cycle 17, ls=1. Changing a to 16'hFFFF mid-run has no effect on the result.
- Reset mid-run: rst_n=0 for 1 cycle at RUN cycle 5 → IDLE with reset flag values and no done pulse. start held during RUN/DONE is not accepted until ready=1.
- SIGNED_CMP_EN build: a=16'h8000, b=16'h0001, sgn=1 → ls=1, done in cycle 2. The same operands with sgn=0 → gt=1. In the non-macro build, sgn=1 → gt=1.
